// File: rtl/gamma_curve_loader.sv
// Curve-RAM loader for the gamma correction stage: identity fill after
// reset, then host curves streamed in as bytes over valid/ready.
module gamma_curve_loader #(
    parameter int ENTRIES     = 768,
    parameter bit INIT_LINEAR = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       load_start,
    input  logic       load_abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       gamma_en_req,
    output logic       gamma_wr,
    output logic [9:0] gamma_wr_addr,
    output logic [7:0] gamma_value,
    output logic       gamma_en,
    output logic       busy,
    output logic       loaded,
    output logic       error
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_INIT,
        ST_IDLE,
        ST_LOAD
    } state_t;

    localparam logic [9:0] LAST = 10'(ENTRIES - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] val_q, val_d;
    logic       en_q, en_d;
    logic       loaded_q, loaded_d;
    logic       error_q, error_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        val_d    = val_q;
        loaded_d = loaded_q;
        error_d  = error_q;
        en_d     = gamma_en_req & loaded_q
                 & (state_q != ST_LOAD);

        unique case (state_q)
            // ST_RST holds outputs quiet while reset is asserted and
            // issues the first fill write on the first free edge.
            ST_RST, ST_INIT: begin
                if (!INIT_LINEAR) begin
                    state_d = ST_IDLE;
                end else begin
                    wr_d   = 1'b1;
                    addr_d = cnt_q;
                    val_d  = cnt_q[7:0];
                    if (cnt_q == LAST) begin
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                        loaded_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 10'd1;
                        state_d = ST_INIT;
                    end
                end
            end
            ST_IDLE: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    loaded_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    error_d  = 1'b1;
                    loaded_d = 1'b0;
                end else if (load_start) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    wr_d   = 1'b1;
                    addr_d = cnt_q;
                    val_d  = in_data;
                    if (cnt_q == LAST) begin
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                        loaded_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_RST;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            val_q    <= '0;
            en_q     <= 1'b0;
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            val_q    <= val_d;
            en_q     <= en_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
        end
    end

    assign in_ready      = (state_q == ST_LOAD);
    assign busy          = (state_q == ST_INIT)
                         | (state_q == ST_LOAD);
    assign gamma_wr      = wr_q;
    assign gamma_wr_addr = addr_q;
    assign gamma_value   = val_q;
    assign gamma_en      = en_q;
    assign loaded        = loaded_q;
    assign error         = error_q;

endmodule
